// File: rtl/sw_score_tracker_pkg.sv
// ============================================================================
// Module  : sw_score_tracker_pkg
// Brief   : Shared score-width defines, tracker state encoding and constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SW_UTIL_DEFS
`define SW_UTIL_DEFS
`define V_E_F_Bit      16
`define Alpha_Beta_Bit 8
`define Match_bit      4
`endif

package sw_score_tracker_pkg;

  localparam int SCORE_W = `V_E_F_Bit;
  localparam int IDX_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } track_state_e;

endpackage

`default_nettype wire

// File: rtl/sw_score_tracker_if.sv
// ============================================================================
// Module  : sw_score_tracker_if
// Brief   : Score beat stream in, result record out (both valid/ready).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sw_score_tracker_if
  import sw_score_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = SCORE_W,
  parameter int IDX_W      = IDX_W_DEFAULT
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_score;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_score;
  logic [IDX_W-1:0]      out_idx;
  logic [IDX_W-1:0]      out_count;
  logic                  out_ovf;

  modport master (
    output in_valid, in_score, in_last, out_ready,
    input  in_ready, out_valid, out_score, out_idx, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_score, in_last, out_ready,
    output in_ready, out_valid, out_score, out_idx, out_count, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/sw_score_tracker_sm_gt.sv
// ============================================================================
// Module  : sw_sm_gt
// Brief   : Combinational strict sign-magnitude compare, gt = (a > b).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_sm_gt #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt
);
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-2:0] a_mag;
  logic [DATA_WIDTH-2:0] b_mag;

  assign a_neg = a[DATA_WIDTH-1];
  assign b_neg = b[DATA_WIDTH-1];
  assign a_mag = a[DATA_WIDTH-2:0];
  assign b_mag = b[DATA_WIDTH-2:0];

  always_comb begin
    gt = 1'b0;
    // +0 and -0 compare equal, so a zero pair never reports greater
    if ((a_mag == '0) && (b_mag == '0)) begin
      gt = 1'b0;
    end else if (a_neg != b_neg) begin
      gt = b_neg;
    end else if (!a_neg) begin
      gt = (a_mag > b_mag);
    end else begin
      gt = (a_mag < b_mag);
    end
  end
endmodule

`default_nettype wire

// File: rtl/sw_score_tracker.sv
// ============================================================================
// Module  : sw_score_tracker
// Brief   : Tracks best score and its first beat index per query; emits one
//           record per query. Optional zero floor via SCORE_TRACK_CLAMP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_score_tracker
  import sw_score_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = SCORE_W,
  parameter int IDX_W      = IDX_W_DEFAULT
) (
  input  wire logic           clk,
  input  wire logic           reset,
  sw_score_tracker_if.slave   bus
);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

  track_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] best_q,  best_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [IDX_W-1:0]      cnt_q,   cnt_d;
  logic                  ovf_q,   ovf_d;

  logic [DATA_WIDTH-1:0] score_eff;
  logic                  score_gt;
  logic                  accept;

`ifdef SCORE_TRACK_CLAMP_EN
  assign score_eff = bus.in_score[DATA_WIDTH-1] ? '0 : bus.in_score;
`else
  assign score_eff = bus.in_score;
`endif

  sw_sm_gt #(.DATA_WIDTH(DATA_WIDTH)) u_gt (
    .a  (score_eff),
    .b  (best_q),
    .gt (score_gt)
  );

  assign accept = bus.in_valid && (state_q != ST_HOLD);

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          best_d  = score_eff;
          idx_d   = '0;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = bus.in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          // Count holds at its ceiling; idx takes the pre-increment count
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_ONE;
          if (score_gt) begin
            best_d = score_eff;
            idx_d  = cnt_q;
          end
          if (bus.in_last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q != ST_HOLD);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_score = best_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_sw_score_tracker.sv
// Directed and scoreboard-checked stimulus for sw_score_tracker, including a
// second instance with a 2-bit count to reach saturation.
`default_nettype none

module tb_sw_score_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sw_score_tracker_if #(.DATA_WIDTH(16), .IDX_W(10)) bus ();
  sw_score_tracker_if #(.DATA_WIDTH(16), .IDX_W(2))  bus2 ();

  sw_score_tracker #(.DATA_WIDTH(16), .IDX_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  sw_score_tracker #(.DATA_WIDTH(16), .IDX_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Present one beat at a negedge and return at the negedge after it is taken.
  task automatic put(input logic [15:0] s, input logic l);
    int n;
    bus.in_valid = 1'b1; bus.in_score = s; bus.in_last = l;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; bad++; $display("FAIL put_timeout in_ready stuck got=%b required=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic put2(input logic [15:0] s, input logic l);
    int n;
    bus2.in_valid = 1'b1; bus2.in_score = s; bus2.in_last = l;
    n = 0;
    while (bus2.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; bad++; $display("FAIL put2_timeout in_ready stuck got=%b required=1", bus2.in_ready); end
    @(negedge clk);
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic int sval(input logic [15:0] s);
`ifdef SCORE_TRACK_CLAMP_EN
    if (s[15]) return 0;
`endif
    return s[15] ? -int'(s[14:0]) : int'(s[14:0]);
  endfunction

  function automatic logic [15:0] sword(input logic [15:0] s);
`ifdef SCORE_TRACK_CLAMP_EN
    if (s[15]) return 16'h0000;
`endif
    return s;
  endfunction

  task automatic test_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required=0", bus.out_valid); end
    total++; if (bus.out_score !== 16'h0) begin bad++; $display("FAIL rst_score got=%h required=0000", bus.out_score); end
    total++; if (bus.out_idx !== 10'd0 || bus.out_count !== 10'd0) begin bad++; $display("FAIL rst_idx_cnt got=%0d/%0d required=0/0", bus.out_idx, bus.out_count); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b required=0", bus.out_ovf); end
    reset = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", bus.in_ready); end
    put(16'h0005, 1'b1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_hold got=%b required=1", bus.out_valid); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.out_score !== 16'h0 || bus.out_count !== 10'd0) begin bad++; $display("FAIL rst_in_hold got=%b/%h/%0d required=0/0000/0", bus.out_valid, bus.out_score, bus.out_count); end
    reset = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_hold_ready got=%b required=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    put(16'h0003, 1'b0);
    put(16'h0007, 1'b0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b required=0", bus.out_valid); end
    put(16'h0005, 1'b1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b required=1", bus.out_valid); end
    total++; if (bus.out_score !== 16'h0007) begin bad++; $display("FAIL basic_score got=%h required=0007", bus.out_score); end
    total++; if (bus.out_idx !== 10'd1) begin bad++; $display("FAIL basic_idx got=%0d required=1", bus.out_idx); end
    total++; if (bus.out_count !== 10'd3 || bus.out_ovf !== 1'b0) begin bad++; $display("FAIL basic_cnt_ovf got=%0d/%b required=3/0", bus.out_count, bus.out_ovf); end
    take();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_release got=%b/%b required=0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_ties();
    put(16'h0004, 1'b0);
    put(16'h0004, 1'b0);
    put(16'h8000, 1'b0);
    put(16'h0000, 1'b1);
    total++; if (bus.out_score !== 16'h0004 || bus.out_idx !== 10'd0 || bus.out_count !== 10'd4) begin bad++; $display("FAIL ties got=%h/%0d/%0d required=0004/0/4", bus.out_score, bus.out_idx, bus.out_count); end
    take();
    // -0 first then +0: equal, so the -0 beat at index 0 is kept
    put(16'h8000, 1'b0);
    put(16'h0000, 1'b1);
    total++; if (bus.out_score !== 16'h0000 && bus.out_score !== 16'h8000) begin bad++; $display("FAIL zero_pair_score got=%h required=zero", bus.out_score); end
`ifdef SCORE_TRACK_CLAMP_EN
    total++; if (bus.out_score !== 16'h0000 || bus.out_idx !== 10'd0) begin bad++; $display("FAIL zero_pair got=%h/%0d required=0000/0", bus.out_score, bus.out_idx); end
`else
    total++; if (bus.out_score !== 16'h8000 || bus.out_idx !== 10'd0) begin bad++; $display("FAIL zero_pair got=%h/%0d required=8000/0", bus.out_score, bus.out_idx); end
`endif
    take();
  endtask

  task automatic test_negative();
    put(16'h8005, 1'b0);
    put(16'h8002, 1'b1);
`ifdef SCORE_TRACK_CLAMP_EN
    total++; if (bus.out_score !== 16'h0000 || bus.out_idx !== 10'd0) begin bad++; $display("FAIL negative got=%h/%0d required=0000/0", bus.out_score, bus.out_idx); end
`else
    total++; if (bus.out_score !== 16'h8002 || bus.out_idx !== 10'd1) begin bad++; $display("FAIL negative got=%h/%0d required=8002/1", bus.out_score, bus.out_idx); end
`endif
    total++; if (bus.out_count !== 10'd2) begin bad++; $display("FAIL negative_cnt got=%0d required=2", bus.out_count); end
    take();
  endtask

  task automatic test_back_to_back();
    put(16'h0010, 1'b0);
    put(16'h0020, 1'b1);
    bus.in_valid = 1'b1; bus.in_score = 16'h0030; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_score !== 16'h0020 || bus.out_idx !== 10'd1 || bus.out_count !== 10'd2) begin
        bad++; $display("FAIL hold_stable cyc=%0d got=%b/%b/%h/%0d/%0d required=1/0/0020/1/2", i, bus.out_valid, bus.in_ready, bus.out_score, bus.out_idx, bus.out_count);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL no_bypass got=%b/%b required=0/1", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_score !== 16'h0030 || bus.out_count !== 10'd1) begin bad++; $display("FAIL held_beat got=%b/%h/%0d required=1/0030/1", bus.out_valid, bus.out_score, bus.out_count); end
    take();
  endtask

  task automatic test_reset_midquery();
    put(16'h0009, 1'b0);
    put(16'h0009, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.out_score !== 16'h0 || bus.out_idx !== 10'd0 || bus.out_count !== 10'd0 || bus.out_ovf !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%0d/%0d/%b required=0/0000/0/0/0", bus.out_valid, bus.out_score, bus.out_idx, bus.out_count, bus.out_ovf);
    end
    reset = 1'b0;
    put(16'h0001, 1'b1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_score !== 16'h0001 || bus.out_idx !== 10'd0 || bus.out_count !== 10'd1) begin
      bad++; $display("FAIL after_reset got=%b/%h/%0d/%0d required=1/0001/0/1", bus.out_valid, bus.out_score, bus.out_idx, bus.out_count);
    end
    take();
  endtask

  task automatic test_overflow();
    put2(16'h0001, 1'b0);
    put2(16'h0002, 1'b0);
    put2(16'h0003, 1'b0);
    total++; if (bus2.out_ovf !== 1'b0 || bus2.out_count !== 2'd3) begin bad++; $display("FAIL ovf_early got=%b/%0d required=0/3", bus2.out_ovf, bus2.out_count); end
    put2(16'h0004, 1'b0);
    put2(16'h0005, 1'b1);
    total++; if (bus2.out_count !== 2'd3 || bus2.out_ovf !== 1'b1) begin bad++; $display("FAIL ovf got=%0d/%b required=3/1", bus2.out_count, bus2.out_ovf); end
    total++; if (bus2.out_score !== 16'h0005 || bus2.out_idx !== 2'd3) begin bad++; $display("FAIL ovf_best got=%h/%0d required=0005/3", bus2.out_score, bus2.out_idx); end
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
    put2(16'h0002, 1'b1);
    total++; if (bus2.out_ovf !== 1'b0 || bus2.out_count !== 2'd1) begin bad++; $display("FAIL ovf_clear got=%b/%0d required=0/1", bus2.out_ovf, bus2.out_count); end
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int q = 0; q < 200; q++) begin
      int len, best_v, best_i, n;
      logic [15:0] s, best_w;
      len = $urandom_range(1, 8);
      best_v = 0; best_i = 0; best_w = 16'h0;
      for (int i = 0; i < len; i++) begin
        s = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 6))};
        if (i == 0 || sval(s) > best_v) begin best_v = sval(s); best_i = i; best_w = sword(s); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        put(s, (i == len - 1));
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_score !== best_w || bus.out_idx !== 10'(best_i) || bus.out_count !== 10'(len) || bus.out_ovf !== 1'b0) begin
        bad++; $display("FAIL rand q=%0d got=%b/%h/%0d/%0d/%b required=1/%h/%0d/%0d/0", q, bus.out_valid, bus.out_score, bus.out_idx, bus.out_count, bus.out_ovf, best_w, best_i, len);
      end
      take();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_score = 16'h0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_score = 16'h0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_ties();
    test_negative();
    test_back_to_back();
    test_reset_midquery();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
